// File: rtl/stall_data_bus.sv
// stall_data_bus: word-addressed RAM responder for the CPU data bus with programmable stall latency.
// Define BUS_TRACE_EN to build the one-cycle-delayed write trace; otherwise trace outputs are tied 0.
module stall_data_bus #(
   parameter int ADDR_WIDTH = 14,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] bus_address,
   input  logic        bus_read,
   input  logic        bus_write,
   input  logic [3:0]  bus_mask,
   input  logic [31:0] bus_wrdata,
   output logic [31:0] bus_rddata,
   output logic        bus_stall,
   output logic        proto_err,
   output logic        trace_we,
   output logic [15:0] trace_addr,
   output logic [31:0] trace_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
         else         res[8*i +: 8] = old_word[8*i +: 8];
      end
      return res;
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_mask;
   logic                  r_is_write;
   logic                  r_proto_err;
   logic [31:0]           r_rddata;
   logic [31:0]           r_mem [DEPTH];
   logic                  w_req;
   logic                  w_latch;
   logic                  w_load_rd;
   logic                  w_mismatch;
   logic                  w_proto_viol;
   logic                  w_commit;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [ADDR_WIDTH-1:0] w_rd_idx;
   logic [31:0]           w_merged;

   assign w_req        = bus_read | bus_write;
   assign w_idx        = r_addr[ADDR_WIDTH+1:2];
   assign w_mismatch   = (bus_address != r_addr) | (bus_write != r_is_write) |
                         (bus_mask != r_mask) | (bus_wrdata != r_wdata);
   assign w_proto_viol = (bus_read & bus_write) | ((r_state == ST_BUSY) & w_req & w_mismatch);
   assign w_commit     = (r_state == ST_RESP) & r_is_write;
   assign w_merged     = byte_merge(r_mem[w_idx], r_wdata, r_mask);
   assign bus_stall    = w_req & (r_state != ST_RESP);
   assign bus_rddata   = r_rddata;
   assign proto_err    = r_proto_err;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state, stall counter and read-capture decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_load_rd   = 1'b0;
      w_rd_idx    = w_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_latch   = 1'b1;
               w_cnt_nxt = CNT_INIT;
               if (LATENCY == 1) begin
                  // Entering RESP straight from IDLE: nothing latched yet, index the live address.
                  w_state_nxt = ST_RESP;
                  w_load_rd   = 1'b1;
                  w_rd_idx    = bus_address[ADDR_WIDTH+1:2];
               end else begin
                  w_state_nxt = ST_BUSY;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!w_req) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  w_state_nxt = ST_RESP;
                  w_load_rd   = 1'b1;
               end else begin
                  w_state_nxt = ST_BUSY;
               end
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, counter, read data and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= 4'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_mask      <= 4'd0;
         r_is_write  <= 1'b0;
         r_rddata    <= 32'd0;
         r_proto_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_latch) begin
            r_addr     <= bus_address;
            r_wdata    <= bus_wrdata;
            r_mask     <= bus_mask;
            r_is_write <= bus_write;
         end
         if (w_load_rd)    r_rddata    <= r_mem[w_rd_idx];
         if (w_proto_viol) r_proto_err <= 1'b1;
      end
   end

   // RAM write port; contents survive reset, but a write pending under reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && w_commit) r_mem[w_idx] <= w_merged;
   end

`ifdef BUS_TRACE_EN
   logic        r_trace_we;
   logic [15:0] r_trace_addr;
   logic [31:0] r_trace_data;

   // Write trace: one-cycle strobe after the committing edge, carrying the merged word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_trace_we   <= 1'b0;
         r_trace_addr <= 16'd0;
         r_trace_data <= 32'd0;
      end else begin
         r_trace_we <= w_commit;
         if (w_commit) begin
            r_trace_addr <= {r_addr[15:2], 2'b00};
            r_trace_data <= w_merged;
         end
      end
   end

   assign trace_we   = r_trace_we;
   assign trace_addr = r_trace_addr;
   assign trace_data = r_trace_data;
`else
   assign trace_we   = 1'b0;
   assign trace_addr = 16'd0;
   assign trace_data = 32'd0;
`endif

endmodule

// File: tb/tb_stall_data_bus.sv
// Scoreboard bench for stall_data_bus: LATENCY=2 instance for the main flows, LATENCY=1 for back-to-back.
module tb_stall_data_bus;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] addr, wdata, rdata, tdata;
   logic        rd, wr, stall, perr, twe;
   logic [3:0]  mask;
   logic [15:0] taddr;
   logic [31:0] addr1, wdata1, rdata1, tdata1;
   logic        rd1, wr1, stall1, perr1, twe1;
   logic [3:0]  mask1;
   logic [15:0] taddr1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model [int];

   stall_data_bus #(.ADDR_WIDTH(14), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus_address(addr), .bus_read(rd), .bus_write(wr),
      .bus_mask(mask), .bus_wrdata(wdata), .bus_rddata(rdata), .bus_stall(stall),
      .proto_err(perr), .trace_we(twe), .trace_addr(taddr), .trace_data(tdata));

   stall_data_bus #(.ADDR_WIDTH(14), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus_address(addr1), .bus_read(rd1), .bus_write(wr1),
      .bus_mask(mask1), .bus_wrdata(wdata1), .bus_rddata(rdata1), .bus_stall(stall1),
      .proto_err(perr1), .trace_we(twe1), .trace_addr(taddr1), .trace_data(tdata1));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      int key;
      key = int'(a[15:2]);
      return model.exists(key) ? model[key] : 32'h0;
   endfunction

   // One well-behaved transfer on the LATENCY=2 instance, including the trace cycle.
   task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      logic [31:0] me, merged;
      me     = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      merged = (model_rd(a) & ~me) | (d & me);
      if (r && !w) exp_q.push_back(model_rd(a));
      addr = a; rd = r; wr = w; wdata = d; mask = m;
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clk);
         check_val($sformatf("stall_c%0d", k), {31'd0, stall}, (k < LAT) ? 32'd1 : 32'd0);
         if (k == LAT && r && !w) check_val("rddata", rdata, exp_q.pop_front());
         tick();
      end
      rd = 1'b0; wr = 1'b0;
      if (w) model[int'(a[15:2])] = merged;
      @(negedge clk);
`ifdef BUS_TRACE_EN
      check_val("trace_we", {31'd0, twe}, {31'd0, w});
      if (w) begin
         check_val("trace_addr", {16'd0, taddr}, {16'd0, a[15:2], 2'b00});
         check_val("trace_data", tdata, merged);
      end
`else
      check_val("trace_we", {31'd0, twe}, 32'd0);
      check_val("trace_addr", {16'd0, taddr}, 32'd0);
      check_val("trace_data", tdata, 32'd0);
`endif
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      addr = 32'd0; rd = 1'b0; wr = 1'b0; wdata = 32'd0; mask = 4'd0;
      addr1 = 32'd0; rd1 = 1'b0; wr1 = 1'b0; wdata1 = 32'd0; mask1 = 4'd0;
      tick(); tick();
      @(negedge clk);
      check_val("rst_rddata", rdata, 32'd0);
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      check_val("rst_perr", {31'd0, perr}, 32'd0);
      check_val("rst_trace", {15'd0, twe, taddr}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Known contents for the words exercised later.
      xfer(1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
      xfer(1'b0, 1'b1, 32'h34, 32'h0, 4'hF);
      xfer(1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
      check_val("perr_clean", {31'd0, perr}, 32'd0);

      // Address change while stalled: flag sticks, latched address wins.
      addr = 32'h30; wr = 1'b1; rd = 1'b0; wdata = 32'hA5A5_A5A5; mask = 4'hF;
      @(negedge clk); check_val("mm_stall0", {31'd0, stall}, 32'd1);
      tick();
      addr = 32'h34;
      @(negedge clk); check_val("mm_perr_pre", {31'd0, perr}, 32'd0);
      tick();
      @(negedge clk);
      check_val("mm_stall_resp", {31'd0, stall}, 32'd0);
      check_val("mm_perr_set", {31'd0, perr}, 32'd1);
      tick();
      wr = 1'b0;
      model[int'(32'h30 >> 2)] = 32'hA5A5_A5A5;
      tick();
      xfer(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      xfer(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);

      // Full write, read back, byte-masked merge, read back.
      xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      xfer(1'b0, 1'b1, 32'h10, 32'h0000_5500, 4'b0010);
      xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      check_val("merge_const", rdata, 32'hDEAD_55EF);
      check_val("perr_sticky", {31'd0, perr}, 32'd1);

      // Reset during BUSY of a write.
      addr = 32'h40; wr = 1'b1; wdata = 32'hCAFE_F00D; mask = 4'hF;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; wr = 1'b0;
      @(negedge clk);
      check_val("rb_rddata", rdata, 32'd0);
      check_val("rb_stall", {31'd0, stall}, 32'd0);
      check_val("rb_perr", {31'd0, perr}, 32'd0);
      check_val("rb_trace", {15'd0, twe, taddr}, 32'd0);
      tick();
      xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

      // Abort: request dropped in BUSY.
      addr = 32'h20; wr = 1'b1; wdata = 32'h1234_5678; mask = 4'hF;
      tick();
      wr = 1'b0;
      @(negedge clk); check_val("ab_stall", {31'd0, stall}, 32'd0);
      tick();
      @(negedge clk); check_val("ab_trace", {31'd0, twe}, 32'd0);
      tick();
      xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      check_val("ab_perr", {31'd0, perr}, 32'd0);

      // LATENCY=1 instance: continuous back-to-back requests.
      for (int t = 0; t < 4; t++) begin
         addr1  = (t % 2 == 0) ? 32'h0 : 32'h4;
         wr1    = (t < 2);
         rd1    = (t >= 2);
         wdata1 = (t == 0) ? 32'h1111_1111 : 32'h2222_2222;
         mask1  = 4'hF;
         if (t >= 2) exp_q.push_back((t == 2) ? 32'h1111_1111 : 32'h2222_2222);
         @(negedge clk); check_val($sformatf("l1_stall_req%0d", t), {31'd0, stall1}, 32'd1);
         tick();
         @(negedge clk); check_val($sformatf("l1_stall_resp%0d", t), {31'd0, stall1}, 32'd0);
         if (t >= 2) check_val("l1_rddata", rdata1, exp_q.pop_front());
         tick();
      end
      rd1 = 1'b0; wr1 = 1'b0;
      @(negedge clk); check_val("l1_perr_clean", {31'd0, perr1}, 32'd0);
      tick();
      addr1 = 32'h8; rd1 = 1'b1; wr1 = 1'b1;
      tick();
      rd1 = 1'b0; wr1 = 1'b0;
      @(negedge clk); check_val("l1_perr_rw", {31'd0, perr1}, 32'd1);
`ifndef BUS_TRACE_EN
      check_val("l1_trace_tied", {31'd0, twe1 | (|taddr1) | (|tdata1)}, 32'd0);
`endif
      tick();
      check_val("sb_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
